// File: rtl/acc_rr_scheduler_pkg.sv
// Shared constants and the FSM state type for the accumulator round-robin scheduler.
package acc_rr_scheduler_pkg;

  localparam int ACC_RESOLUTION    = 32;
  localparam int ACC_DATA_DEPTH    = 8;
  localparam int ACC_SCHED_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } acc_sched_state_t;

endpackage

// File: rtl/acc_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requesting lane after last_grant, modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_req_o
);

  logic [ID_W-1:0] idx;

  // Walk from lowest to highest priority so the last hit (nearest lane after last_grant) wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    idx       = '0;
    any_req_o = |req_i;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = ID_W'((int'(last_grant_i) + off) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_oh_o      = '0;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/acc_rr_scheduler.sv
// Shares one accumulator between NUM_REQ lanes: round-robin grant, operand capture,
// result collection with a watchdog, and a valid/ready response tagged with the lane ID.
module acc_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ACC_RESOLUTION = acc_rr_scheduler_pkg::ACC_RESOLUTION,
  parameter int ACC_DATA_DEPTH = acc_rr_scheduler_pkg::ACC_DATA_DEPTH,
  parameter int TIMEOUT_CYCLES = acc_rr_scheduler_pkg::ACC_SCHED_TIMEOUT,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i [NUM_REQ],
  input  logic [ACC_RESOLUTION-1:0] req_data_i  [NUM_REQ][ACC_DATA_DEPTH],
  input  logic [ACC_RESOLUTION-1:0] req_bias_i  [NUM_REQ],
  output logic                      req_ready_o [NUM_REQ],
  output logic                      acc_valid_o [ACC_DATA_DEPTH],
  output logic [ACC_RESOLUTION-1:0] acc_data_o  [ACC_DATA_DEPTH],
  output logic [ACC_RESOLUTION-1:0] acc_bias_o,
  input  logic                      acc_res_valid_i,
  input  logic [ACC_RESOLUTION-1:0] acc_res_data_i,
  output logic                      acc_res_ready_o,
  output logic                      rsp_valid_o,
  output logic [ACC_RESOLUTION-1:0] rsp_data_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic                      rsp_err_o,
  input  logic                      rsp_ready_i,
  output logic                      busy_o
);
  import acc_rr_scheduler_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  acc_sched_state_t          state_q, state_d;
  logic [ID_W-1:0]           last_grant_q, last_grant_d;
  logic [ID_W-1:0]           id_q, id_d;
  logic [ACC_RESOLUTION-1:0] data_q [ACC_DATA_DEPTH];
  logic [ACC_RESOLUTION-1:0] data_d [ACC_DATA_DEPTH];
  logic [ACC_RESOLUTION-1:0] bias_q, bias_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ACC_RESOLUTION-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i        (req_vec),
    .last_grant_i (last_grant_q),
    .gnt_oh_o     (gnt_oh),
    .gnt_idx_o    (gnt_idx),
    .any_req_o    (any_req)
  );

  // Ready is qualified with reset so no lane sees an accept that is never captured.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_vec[gi]     = req_valid_i[gi];
    assign req_ready_o[gi] = rst_ni && (state_q == IDLE) && gnt_oh[gi];
  end

  for (genvar gi = 0; gi < ACC_DATA_DEPTH; gi++) begin : g_acc
    assign acc_valid_o[gi] = (state_q == ISSUE);
    assign acc_data_o[gi]  = data_q[gi];
  end

  assign acc_bias_o      = bias_q;
  assign acc_res_ready_o = (state_q == WAIT);
  assign rsp_valid_o     = (state_q == RESP);
  assign rsp_data_o      = rsp_data_q;
  assign rsp_id_o        = id_q;
  assign rsp_err_o       = rsp_err_q;
  assign busy_o          = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    bias_d       = bias_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          data_d       = req_data_i[gnt_idx];
          bias_d       = req_bias_i[gnt_idx];
          id_d         = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A result arriving on the timeout cycle still wins.
        if (acc_res_valid_i) begin
          rsp_data_d = acc_res_data_i;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      bias_q       <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      for (int i = 0; i < ACC_DATA_DEPTH; i++) data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      bias_q       <= bias_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Directed bench for acc_rr_scheduler: grant order, latency, stability, watchdog, backpressure, reset.
module tb_acc_rr_scheduler;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i [N];
  logic [W-1:0]  req_data_i  [N][D];
  logic [W-1:0]  req_bias_i  [N];
  logic          req_ready_o [N];
  logic          acc_valid_o [D];
  logic [W-1:0]  acc_data_o  [D];
  logic [W-1:0]  acc_bias_o;
  logic          acc_res_valid_i;
  logic [W-1:0]  acc_res_data_i;
  logic          acc_res_ready_o;
  logic          rsp_valid_o;
  logic [W-1:0]  rsp_data_o;
  logic [1:0]    rsp_id_o;
  logic          rsp_err_o;
  logic          rsp_ready_i;
  logic          busy_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  acc_rr_scheduler dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_data_i      (req_data_i),
    .req_bias_i      (req_bias_i),
    .req_ready_o     (req_ready_o),
    .acc_valid_o     (acc_valid_o),
    .acc_data_o      (acc_data_o),
    .acc_bias_o      (acc_bias_o),
    .acc_res_valid_i (acc_res_valid_i),
    .acc_res_data_i  (acc_res_data_i),
    .acc_res_ready_o (acc_res_ready_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_id_o        (rsp_id_o),
    .rsp_err_o       (rsp_err_o),
    .rsp_ready_i     (rsp_ready_i),
    .busy_o          (busy_o)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [N-1:0] ready_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = req_ready_o[i];
    return v;
  endfunction

  // Accumulator model: sum of the presented partial sums plus bias.
  function automatic logic [W-1:0] acc_model();
    logic [W-1:0] s;
    s = acc_bias_o;
    for (int k = 0; k < D; k++) s = s + acc_data_o[k];
    return s;
  endfunction

  // Called in IDLE with requests already driven; returns in IDLE after the response handshake.
  task automatic run_txn(input int lane, input int delay, input logic [W-1:0] exp_sum,
                         input string tag, input bit drop);
    #1;
    chk($sformatf("%s_grant", tag), W'(ready_vec()), W'(1 << lane));
    tick();
    chk($sformatf("%s_pulse", tag), W'(ready_vec()), '0);
    chk($sformatf("%s_accv0", tag), W'(acc_valid_o[0]), 1);
    chk($sformatf("%s_accv7", tag), W'(acc_valid_o[D-1]), 1);
    if (drop) req_valid_i[lane] = 1'b0;
    tick();
    chk($sformatf("%s_wait_accv", tag), W'(acc_valid_o[0]), 0);
    chk($sformatf("%s_wait_rdy", tag), W'(acc_res_ready_o), 1);
    repeat (delay - 1) tick();
    acc_res_valid_i = 1'b1;
    acc_res_data_i  = acc_model();
    tick();
    acc_res_valid_i = 1'b0;
    acc_res_data_i  = '0;
    chk($sformatf("%s_rspv", tag), W'(rsp_valid_o), 1);
    chk($sformatf("%s_rspid", tag), W'(rsp_id_o), W'(lane));
    chk($sformatf("%s_rspdata", tag), rsp_data_o, exp_sum);
    chk($sformatf("%s_rsperr", tag), W'(rsp_err_o), 0);
    chk($sformatf("%s_resp_rdy", tag), W'(acc_res_ready_o), 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk($sformatf("%s_idle_rspv", tag), W'(rsp_valid_o), 0);
    chk($sformatf("%s_idle_busy", tag), W'(busy_o), 0);
  endtask

  initial begin
    int n;
    rst_ni          = 1'b0;
    acc_res_valid_i = 1'b0;
    acc_res_data_i  = '0;
    rsp_ready_i     = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = 1'b0;
      req_bias_i[i]  = '0;
      for (int k = 0; k < D; k++) req_data_i[i][k] = '0;
    end
    tick();
    tick();

    // Reset state
    chk("rst_busy", W'(busy_o), 0);
    chk("rst_rspv", W'(rsp_valid_o), 0);
    chk("rst_accv", W'(acc_valid_o[0]), 0);
    chk("rst_accrdy", W'(acc_res_ready_o), 0);
    chk("rst_accdata", acc_data_o[0], 0);
    chk("rst_accbias", acc_bias_o, 0);
    chk("rst_rspdata", rsp_data_o, 0);
    chk("rst_rspid", W'(rsp_id_o), 0);
    chk("rst_rsperr", W'(rsp_err_o), 0);
    chk("rst_ready", W'(ready_vec()), 0);
    rst_ni = 1'b1;
    tick();

    // Single lane: lane 2, data 1..8, bias 100 -> 136, result 10 cycles after issue
    for (int k = 0; k < D; k++) req_data_i[2][k] = W'(k + 1);
    req_bias_i[2]  = 100;
    req_valid_i[2] = 1'b1;
    run_txn(2, 10, 136, "single", 1'b1);

    // Round-robin from reset: lane n data n*10+k, bias n -> sum 81n+28
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_bias_i[i]  = W'(i);
      req_valid_i[i] = 1'b1;
      for (int k = 0; k < D; k++) req_data_i[i][k] = W'(i * 10 + k);
    end
    run_txn(0, 3, 28,  "rr0", 1'b0);
    run_txn(1, 3, 109, "rr1", 1'b0);
    run_txn(2, 3, 190, "rr2", 1'b0);
    run_txn(3, 3, 271, "rr3", 1'b0);
    run_txn(0, 3, 28,  "rr4", 1'b0);
    run_txn(1, 3, 109, "rr5", 1'b0);
    for (int i = 0; i < N; i++) req_valid_i[i] = 1'b0;

    // Data stability: lane 0 data all 5, bias 7 -> 47; inputs scrambled after grant
    for (int k = 0; k < D; k++) req_data_i[0][k] = 5;
    req_bias_i[0]  = 7;
    req_valid_i[0] = 1'b1;
    #1;
    chk("stab_grant", W'(ready_vec()), 1);
    tick();
    req_valid_i[0] = 1'b0;
    for (int k = 0; k < D; k++) req_data_i[0][k] = 32'hDEAD_0000 + W'(k);
    req_bias_i[0] = 32'hBEEF;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stab_d0_c%0d", c), acc_data_o[0], 5);
      chk($sformatf("stab_d7_c%0d", c), acc_data_o[D-1], 5);
      chk($sformatf("stab_bias_c%0d", c), acc_bias_o, 7);
      tick();
    end
    acc_res_valid_i = 1'b1;
    acc_res_data_i  = acc_model();
    tick();
    acc_res_valid_i = 1'b0;
    chk("stab_rspdata", rsp_data_o, 47);
    chk("stab_rspid", W'(rsp_id_o), 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Watchdog: lane 3 never gets a result
    for (int k = 0; k < D; k++) req_data_i[3][k] = 1;
    req_bias_i[3]  = 0;
    req_valid_i[3] = 1'b1;
    #1;
    chk("to_grant", W'(ready_vec()), 8);
    tick();
    req_valid_i[3] = 1'b0;
    tick();
    n = 0;
    while (rsp_valid_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("to_latency", W'(n), 64);
    chk("to_err", W'(rsp_err_o), 1);
    chk("to_data", rsp_data_o, 0);
    chk("to_id", W'(rsp_id_o), 3);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    for (int k = 0; k < D; k++) req_data_i[1][k] = W'(k);
    req_bias_i[1]  = 2;
    req_valid_i[1] = 1'b1;
    run_txn(1, 2, 30, "post_to", 1'b1);

    // Response backpressure: lane 0 (data 3s, bias 1 -> 25) stalls while lanes 1 and 3 wait
    for (int k = 0; k < D; k++) req_data_i[0][k] = 3;
    req_bias_i[0]  = 1;
    req_valid_i[0] = 1'b1;
    #1;
    chk("bp_grant", W'(ready_vec()), 1);
    tick();
    req_valid_i[0] = 1'b0;
    req_valid_i[1] = 1'b1;
    req_valid_i[3] = 1'b1;
    tick();
    tick();
    acc_res_valid_i = 1'b1;
    acc_res_data_i  = acc_model();
    tick();
    acc_res_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("bp_rspv_c%0d", c), W'(rsp_valid_o), 1);
      chk($sformatf("bp_data_c%0d", c), rsp_data_o, 25);
      chk($sformatf("bp_ready_c%0d", c), W'(ready_vec()), 0);
      chk($sformatf("bp_busy_c%0d", c), W'(busy_o), 1);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    run_txn(1, 2, 30, "bp_l1", 1'b1);
    run_txn(3, 2, 8,  "bp_l3", 1'b1);

    // Reset during WAIT: lane 2 transaction abandoned, lane 0 regains top priority
    for (int k = 0; k < D; k++) req_data_i[2][k] = W'(k + 1);
    req_bias_i[2]  = 100;
    req_valid_i[2] = 1'b1;
    #1;
    chk("mr_grant", W'(ready_vec()), 4);
    tick();
    tick();
    tick();
    chk("mr_inwait", W'(acc_res_ready_o), 1);
    rst_ni         = 1'b0;
    req_valid_i[0] = 1'b1;
    tick();
    chk("mr_busy", W'(busy_o), 0);
    chk("mr_accrdy", W'(acc_res_ready_o), 0);
    chk("mr_accdata", acc_data_o[0], 0);
    chk("mr_accbias", acc_bias_o, 0);
    chk("mr_rspv", W'(rsp_valid_o), 0);
    chk("mr_rspdata", rsp_data_o, 0);
    chk("mr_ready", W'(ready_vec()), 0);
    rst_ni = 1'b1;
    run_txn(0, 3, 25,  "mr_l0", 1'b1);
    run_txn(2, 2, 136, "mr_l2", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
